key_mapper: RTL
===============

KEY_MAPPER -- requirements
Module: key_mapper

Interface
REQ-001 Parameter: CLK_HZ, default 100000000, sys_clk frequency in Hz.
REQ-002 Parameter: TICK_HZ, default 1000, debounce sample rate in Hz.
REQ-003 Parameter: DEB_TICKS, default 10, consecutive agreeing samples needed to accept a key change.
REQ-004 Port: sys_clk, input, 1, the single clock; all logic SHALL be rising-edge on sys_clk.
REQ-005 Port: rst_n, input, 1, reset that SHALL be asynchronous and active-low.
REQ-006 Port: en, input, 1, play enable; high in free-play mode.
REQ-007 Port: keys, input, 7, raw piano keys, active-high, asynchronous to sys_clk; bit0 = key 1.
REQ-008 Port: map1..map7, input, 7 each, note code per key from the adjust stage; 0 = unassigned.
REQ-009 Port: note, output, 7, currently sounding note code; 0 = silence.
REQ-010 Port: note_on, output, 1, one-cycle pulse when a note starts.
REQ-011 Port: note_off, output, 1, one-cycle pulse when a note ends.
REQ-012 Port: key_idx, output, 3, held key number 1..7; 0 = none.

Function
REQ-013 Each keys bit SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Tick counter SHALL count 0..CLK_HZ/TICK_HZ-1, assert tick for one cycle at terminal count, then wrap to 0.
REQ-015 Per key, the debounced state SHALL change only after DEB_TICKS consecutive ticks where the synced value differs from it; a tick with agreement SHALL clear that key's count.
REQ-016 A key SHALL be eligible when its debounced state is 1 and its map value is nonzero.
REQ-017 Selection priority SHALL be the lowest-numbered eligible key.
REQ-018 FSM states SHALL be IDLE and PLAY.
REQ-019 In IDLE with en=1 and any eligible key: next cycle state=PLAY, key_idx=selected number, note=its map value, note_on=1 for exactly one cycle.
REQ-020 In PLAY, note SHALL stay at the value latched on entry; later map changes SHALL NOT alter it.
REQ-021 In PLAY, presses of other keys SHALL be ignored (no retrigger, no steal).
REQ-022 In PLAY, when the held key's debounced state falls or en=0: next cycle note=0, key_idx=0, note_off=1 for one cycle, state=IDLE.
REQ-023 After PLAY->IDLE, a still-eligible key SHALL start a new note no earlier than the following cycle; there is always at least one silent cycle.
REQ-024 note_on and note_off SHALL never be asserted in the same cycle.
REQ-025 In IDLE with en=0, all key activity SHALL be ignored, but debouncing SHALL continue.
REQ-026 Latency SHALL be one sys_clk from debounced-state change to note_on/note_off.

Reset
REQ-027 While rst_n=0: note=0, note_on=0, note_off=0, key_idx=0, state=IDLE, tick counter=0, all debounced states and counts=0, synchronizers=0.
REQ-028 Reset asserted mid-PLAY SHALL clear outputs immediately without a note_off pulse.
REQ-029 After release, the first tick SHALL occur CLK_HZ/TICK_HZ cycles later.

Verification (bench uses CLK_HZ=1000, TICK_HZ=100, DEB_TICKS=3 -> tick every 10 cycles)
REQ-030 Press key 3 steadily with en=1 and map3=7'd21 -> exactly one note_on; note=21 and key_idx=3 after the 3rd tick past synchronization; release -> note_off 3 ticks later, note=0.
REQ-031 Key 2 bounces 1-0-1-0 with each level held 5 cycles, then stays 0 -> no note_on and no note_off.
REQ-032 Hold key 5 (map5=30), press key 1 (map1=10) -> note stays 30; release key 5 -> note_off, one silent cycle, then note_on with note=10, key_idx=1.
REQ-033 Hold key 4 and drive map4 from 12 to 40 mid-note -> note stays 12; en drop -> note_off next cycle.
REQ-034 map2=0 and key 2 pressed alone -> no note_on; with key 2 and key 6 pressed (map6=9) -> note=9, key_idx=6.
REQ-035 Assert rst_n=0 mid-PLAY -> note=0, key_idx=0 immediately, no note_off pulse; after release with key still held -> note_on after 3 ticks.

Source files
------------

// File: rtl/key_mapper.sv
// +-----------------------------------------------------------------------------
// | key_mapper : debounced 7-key piano front end producing a monophonic note
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module key_mapper #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1000,
  parameter int DEB_TICKS = 10
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] keys,
  input  logic [6:0] map1,
  input  logic [6:0] map2,
  input  logic [6:0] map3,
  input  logic [6:0] map4,
  input  logic [6:0] map5,
  input  logic [6:0] map6,
  input  logic [6:0] map7,
  output logic [6:0] note,
  output logic       note_on,
  output logic       note_off,
  output logic [2:0] key_idx
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int DCW      = $clog2(DEB_TICKS + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_TICKS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [6:0]      sync1, sync2;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [6:0]      deb;
  logic [6:0]      eligible;
  logic [6:0]      map_arr [7];
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic [6:0]      sel_note;
  logic            held;
  logic [6:0]      note_nxt;
  logic [2:0]      idx_nxt;
  logic            on_nxt, off_nxt;

  assign map_arr[0] = map1;
  assign map_arr[1] = map2;
  assign map_arr[2] = map3;
  assign map_arr[3] = map4;
  assign map_arr[4] = map5;
  assign map_arr[5] = map6;
  assign map_arr[6] = map7;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= keys;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  genvar k;
  generate
    for (k = 0; k < 7; k++) begin : g_key
      logic [DCW-1:0] cnt;
      logic           level;

      // Count only consecutive disagreeing ticks; any agreeing tick restarts.
      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (tick) begin
          if (sync2[k] != level) begin
            if (cnt == DEB_LAST) begin
              level <= ~level;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
      end

      assign deb[k]      = level;
      assign eligible[k] = level && (map_arr[k] != 7'd0);
    end
  endgenerate

  // Descending scan so the lowest-numbered eligible key wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    sel_note  = 7'd0;
    for (int i = 6; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i + 1);
        sel_note  = map_arr[i];
      end
    end
  end

  always_comb begin
    held = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (key_idx == 3'(i + 1)) held = deb[i];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      note     <= '0;
      key_idx  <= '0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
    end else begin
      state    <= state_nxt;
      note     <= note_nxt;
      key_idx  <= idx_nxt;
      note_on  <= on_nxt;
      note_off <= off_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    note_nxt  = note;
    idx_nxt   = key_idx;
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (en && sel_found) begin
          state_nxt = PLAY;
          note_nxt  = sel_note;
          idx_nxt   = sel_idx;
          on_nxt    = 1'b1;
        end
      end
      PLAY: begin
        if (!held || !en) begin
          state_nxt = IDLE;
          note_nxt  = 7'd0;
          idx_nxt   = 3'd0;
          off_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        note_nxt  = 7'd0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

endmodule

`default_nettype wire
